// File: rtl/zjh_scan_display.sv
// Multiplexed BCD 7-segment scanner with a shadow register, a one-cycle ghost guard
// between digit slots, and a frame pulse. Define ZJH_LZB_EN to enable leading-zero blanking.
module zjh_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  Clock,
    input  logic                  Aclr,
    input  logic [4*DIGITS-1:0]   Data,
    input  logic                  Load,
    input  logic                  Blank,
    output logic [DIGITS-1:0]     Sel,
    output logic [6:0]            Seg,
    output logic                  Frame
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   sel_q,    sel_d;
    logic [6:0]          seg_q,    seg_d;
    logic                frame_q,  frame_d;

    logic       tick;
    logic [3:0] cur_digit;
    logic       force_off;

    // Segment order is a..g from bit 6 down to bit 0; non-BCD codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b0011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1110011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = shadow_q[4*i +: 4];
            end
        end
    end

`ifdef ZJH_LZB_EN
    // upper_zero[g] is set when shadow digits g..DIGITS-1 are all zero.
    logic [DIGITS-1:1] upper_zero;
    logic              suppress;

    for (genvar g = 1; g < DIGITS; g++) begin : g_lz
        assign upper_zero[g] = ~|shadow_q[4*DIGITS-1:4*g];
    end

    always_comb begin
        suppress = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                suppress = upper_zero[i];
            end
        end
    end

    assign force_off = Blank | suppress;
`else
    assign force_off = Blank;
`endif

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        shadow_d = Load ? Data : shadow_q;

        // The tick edge opens the guard cycle; the following edge enables the new index.
        sel_d = '1;
        if (!tick) begin
            for (int i = 0; i < DIGITS; i++) begin
                sel_d[i] = (idx_q != IDX_W'(i));
            end
        end

        seg_d   = (tick || force_off) ? 7'b0000000 : seg_decode(cur_digit);
        frame_d = tick && (idx_q == IDX_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments; the shadow register is
    // reset as well because it drives visible segments straight after reset release.
    always_ff @(posedge Clock or negedge Aclr) begin
        if (!Aclr) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            sel_q    <= '1;
            seg_q    <= 7'b0000000;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
            frame_q  <= frame_d;
        end
    end

    assign Sel   = sel_q;
    assign Seg   = seg_q;
    assign Frame = frame_q;

endmodule
